uart_tx: RTL and testbench

Serial UART transmitter that drives the line consumed by the uart_rx receiver. It uses the same 16x oversampled clock domain, so one bit time equals OVERSAMPLE clock cycles. It accepts parallel bytes through a valid/ready handshake into a one-deep holding register, which allows back-to-back frames with zero idle gap. Frame format is LSB first: start bit (0), DATA_BITS data bits, optional parity bit, then STOP_BITS stop bits (1).

---
 rtl/uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// UART transmitter: one-deep holding register, LSB-first framing with
// optional parity and 1..2 stop bits, zero-gap back-to-back frames.
// Ports:
//   tx_clock    oversampled clock (OVERSAMPLE cycles per bit)
//   tx_reset_n  synchronous active-low reset
//   tx_enable   allow new frames to start
//   tx_valid    tx_data valid
//   tx_data     byte to send
//   tx_ready    holding register can accept
//   tx_output   serial line, idle high (registered)
//   tx_busy     frame on the line (registered)
//   tx_done     pulse in the last cycle of each frame (registered)
module uart_tx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic                 tx_clock,
  input  logic                 tx_reset_n,
  input  logic                 tx_enable,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx_output,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam int IW = 3;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 full_q, full_d;
  logic                 par_q, par_d;
  logic                 line_q, line_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 cnt_last;
  logic                 load;
  logic                 odd;

  assign odd       = (PARITY_ODD != 0);
  assign tx_ready  = tx_enable & ~full_q;
  assign tx_output = line_q;
  assign tx_busy   = busy_q;
  assign tx_done   = done_q;
  assign cnt_last  = (cnt_q == CW'(OVERSAMPLE - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    hold_d  = hold_q;
    full_d  = full_q;
    par_d   = par_q;
    line_d  = line_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    load    = 1'b0;

    if (state_q != IDLE)
      cnt_d = cnt_last ? '0 : cnt_q + 1'b1;

    unique case (state_q)
      IDLE: begin
        line_d = 1'b1;
        busy_d = 1'b0;
        if (full_q && tx_enable) begin
          load    = 1'b1;
          state_d = START;
          line_d  = 1'b0;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_last) begin
          state_d = DATA;
          idx_d   = '0;
          line_d  = shift_q[0];
        end
      end
      DATA: begin
        if (cnt_last) begin
          if (idx_q == IW'(DATA_BITS - 1)) begin
            idx_d = '0;
            if (PARITY_EN != 0) begin
              state_d = PARITY;
              line_d  = par_q;
            end else begin
              state_d = STOP;
              line_d  = 1'b1;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            shift_d = shift_q >> 1;
            line_d  = shift_q[1];
          end
        end
      end
      PARITY: begin
        if (cnt_last) begin
          state_d = STOP;
          line_d  = 1'b1;
          idx_d   = '0;
        end
      end
      STOP: begin
        // Registered pulse: raise it one cycle early so it lands
        // on the final stop cycle.
        if (idx_q == IW'(STOP_BITS - 1) &&
            cnt_q == CW'(OVERSAMPLE - 2))
          done_d = 1'b1;
        if (cnt_last) begin
          if (idx_q == IW'(STOP_BITS - 1)) begin
            idx_d = '0;
            if (full_q && tx_enable) begin
              load    = 1'b1;
              state_d = START;
              line_d  = 1'b0;
            end else begin
              state_d = IDLE;
              busy_d  = 1'b0;
            end
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        line_d  = 1'b1;
        busy_d  = 1'b0;
      end
    endcase

    if (load) begin
      shift_d = hold_q;
      par_d   = (^hold_q) ^ odd;
      full_d  = 1'b0;
    end

    // A capture on the load edge wins: the register ends full.
    if (tx_valid && tx_ready) begin
      hold_d = tx_data;
      full_d = 1'b1;
    end
  end

  always_ff @(posedge tx_clock) begin
    if (!tx_reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      hold_q  <= '0;
      full_q  <= 1'b0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      hold_q  <= hold_d;
      full_q  <= full_d;
      par_q   <= par_d;
      line_q  <= line_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: default instance plus even/odd
// parity instances; line checked against a bit-period model.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       valid = 1'b0;
  logic       p_valid = 1'b0;
  logic [7:0] data = 8'h00;
  logic       ready, line, busy, done;
  logic       pe_ready, pe_line, pe_busy, pe_done;
  logic       po_ready, po_line, po_busy, po_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uart_tx u_dut (
    .tx_clock  (clk),
    .tx_reset_n(rst_n),
    .tx_enable (en),
    .tx_valid  (valid),
    .tx_data   (data),
    .tx_ready  (ready),
    .tx_output (line),
    .tx_busy   (busy),
    .tx_done   (done)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .tx_clock  (clk),
    .tx_reset_n(rst_n),
    .tx_enable (en),
    .tx_valid  (p_valid),
    .tx_data   (data),
    .tx_ready  (pe_ready),
    .tx_output (pe_line),
    .tx_busy   (pe_busy),
    .tx_done   (pe_done)
  );

  uart_tx #(.PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .tx_clock  (clk),
    .tx_reset_n(rst_n),
    .tx_enable (en),
    .tx_valid  (p_valid),
    .tx_data   (data),
    .tx_ready  (po_ready),
    .tx_output (po_line),
    .tx_busy   (po_busy),
    .tx_done   (po_done)
  );

  // Expected line level in 1-based period k of a frame (16 cycles/bit).
  function automatic logic exp_bit(input logic [7:0] d, input int k,
                                   input bit pe, input bit odd);
    int b;
    b = (k - 1) / 16;
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
    if (pe && b == 9) return (^d) ^ odd;
    return 1'b1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    valid = 1'b0;
    en    = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if ({line, busy, done, ready} !== 4'b1001) begin
      failures++;
      $display("FAIL reset: got lbdr=%b want 1001",
               {line, busy, done, ready});
    end
  endtask

  task automatic test_single();
    logic [2:0] e;
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h55;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    data  = 8'hFF;
    for (int k = 1; k <= 161; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 160) e = {exp_bit(8'h55, k, 0, 0), 1'b1, k == 160};
      else          e = 3'b100;
      checks++;
      if ({line, busy, done} !== e) begin
        failures++;
        $display("FAIL single k=%0d: got lbd=%b want %b",
                 k, {line, busy, done}, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] e;
    @(negedge clk);
    valid = 1'b1;
    data  = 8'hA3;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 321; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 160)
        e = {exp_bit(8'hA3, k, 0, 0), 1'b1, k == 160};
      else if (k <= 320)
        e = {exp_bit(8'h0F, k - 160, 0, 0), 1'b1, k == 320};
      else
        e = 3'b100;
      checks++;
      if ({line, busy, done} !== e) begin
        failures++;
        $display("FAIL b2b k=%0d: got lbd=%b want %b",
                 k, {line, busy, done}, e);
      end
      if (k == 41 || k == 100 || k == 160) begin
        checks++;
        if (ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_ready_held k=%0d: got %b want 0", k, ready);
        end
      end
      if (k == 161) begin
        checks++;
        if (ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready_free: got %b want 1", ready);
        end
      end
      if (k == 40) begin
        valid = 1'b1;
        data  = 8'h0F;
      end
      if (k == 41) begin
        valid = 1'b0;
        data  = 8'h00;
      end
    end
  endtask

  task automatic test_parity();
    logic [2:0] ee, eo;
    @(negedge clk);
    p_valid = 1'b1;
    data    = 8'h07;
    @(posedge clk);
    @(negedge clk);
    p_valid = 1'b0;
    data    = 8'h00;
    for (int k = 1; k <= 177; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 176) begin
        ee = {exp_bit(8'h07, k, 1, 0), 1'b1, k == 176};
        eo = {exp_bit(8'h07, k, 1, 1), 1'b1, k == 176};
      end else begin
        ee = 3'b100;
        eo = 3'b100;
      end
      checks++;
      if ({pe_line, pe_busy, pe_done} !== ee) begin
        failures++;
        $display("FAIL par_even k=%0d: got lbd=%b want %b",
                 k, {pe_line, pe_busy, pe_done}, ee);
      end
      checks++;
      if ({po_line, po_busy, po_done} !== eo) begin
        failures++;
        $display("FAIL par_odd k=%0d: got lbd=%b want %b",
                 k, {po_line, po_busy, po_done}, eo);
      end
      if (k == 152) begin
        checks++;
        if ({pe_line, po_line} !== 2'b10) begin
          failures++;
          $display("FAIL par_bit: got even/odd=%b want 10",
                   {pe_line, po_line});
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [2:0] e;
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h00;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 250; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 70) e = {exp_bit(8'h00, k, 0, 0), 1'b1, 1'b0};
      else         e = 3'b100;
      checks++;
      if ({line, busy, done} !== e) begin
        failures++;
        $display("FAIL rst_mid k=%0d: got lbd=%b want %b",
                 k, {line, busy, done}, e);
      end
      if (k == 71) begin
        checks++;
        if (ready !== 1'b1) begin
          failures++;
          $display("FAIL rst_mid_ready: got %b want 1", ready);
        end
        rst_n = 1'b1;
      end
      if (k == 70) rst_n = 1'b0;
    end
  endtask

  task automatic test_stream();
    logic [7:0] bytes [3];
    logic [2:0] e;
    int         i;
    int         dones;
    logic       rdy;
    bytes[0] = 8'h00;
    bytes[1] = 8'hFF;
    bytes[2] = 8'h5A;
    dones = 0;
    @(negedge clk);
    valid = 1'b1;
    data  = bytes[0];
    @(posedge clk);
    @(negedge clk);
    i     = 1;
    data  = bytes[1];
    rdy   = ready;
    for (int k = 1; k <= 481; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid && rdy) i++;
      if (i < 3) data = bytes[i];
      else       valid = 1'b0;
      rdy = ready;
      if (done === 1'b1) dones++;
      if (k <= 480)
        e = {exp_bit(bytes[(k - 1) / 160], ((k - 1) % 160) + 1, 0, 0),
             1'b1, (k % 160) == 0};
      else
        e = 3'b100;
      checks++;
      if ({line, busy, done} !== e) begin
        failures++;
        $display("FAIL stream k=%0d: got lbd=%b want %b",
                 k, {line, busy, done}, e);
      end
    end
    checks++;
    if (dones != 3 || i != 3) begin
      failures++;
      $display("FAIL stream_count: got dones=%0d sent=%0d want 3/3",
               dones, i);
    end
  endtask

  task automatic test_enable();
    logic [2:0] e;
    @(negedge clk);
    valid = 1'b1;
    data  = 8'h3C;
    @(posedge clk);
    @(negedge clk);
    valid = 1'b0;
    for (int k = 1; k <= 361; k++) begin
      @(posedge clk);
      @(negedge clk);
      if (k <= 160)
        e = {exp_bit(8'h3C, k, 0, 0), 1'b1, k == 160};
      else if (k <= 200)
        e = 3'b100;
      else if (k <= 360)
        e = {exp_bit(8'hC5, k - 200, 0, 0), 1'b1, k == 360};
      else
        e = 3'b100;
      checks++;
      if ({line, busy, done} !== e) begin
        failures++;
        $display("FAIL enable k=%0d: got lbd=%b want %b",
                 k, {line, busy, done}, e);
      end
      if (k == 51 || k == 180) begin
        checks++;
        if (ready !== 1'b0) begin
          failures++;
          $display("FAIL enable_ready_off k=%0d: got %b want 0",
                   k, ready);
        end
      end
      if (k == 201) begin
        checks++;
        if (ready !== 1'b1) begin
          failures++;
          $display("FAIL enable_ready_on: got %b want 1", ready);
        end
      end
      if (k == 20) begin
        valid = 1'b1;
        data  = 8'hC5;
      end
      if (k == 21) begin
        valid = 1'b0;
        data  = 8'h00;
      end
      if (k == 50)  en = 1'b0;
      if (k == 200) en = 1'b1;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_parity();
    test_reset_mid();
    test_stream();
    test_enable();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
